// File: rtl/clkdiv_pkg.sv
// rtl/clkdiv_pkg.sv - shared types and defaults for the gated clock divider
package clkdiv_pkg;

  localparam int CD_DIV_W = 4;

  typedef enum logic {
    CD_IDLE = 1'b0,
    CD_RUN  = 1'b1
  } cd_state_e;

endpackage

// File: rtl/clkdiv_half_cnt.sv
// rtl/clkdiv_half_cnt.sv - half-period counter with terminal flag against the latched ratio
module clkdiv_half_cnt
  import clkdiv_pkg::*;
#(
  parameter int DIV_W = CD_DIV_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [DIV_W-1:0] limit,
  output logic             term
);

  logic [DIV_W-1:0] cnt;

  // Terminal is compared before incrementing, so an all-ones limit never wraps the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign term = (cnt == limit);

endmodule

// File: rtl/clkdiv_gated_buf.sv
// rtl/clkdiv_gated_buf.sv - registered even-ratio clock divider with glitch-free start/stop
module clkdiv_gated_buf
  import clkdiv_pkg::*;
#(
  parameter int DIV_W = CD_DIV_W
) (
  input  logic             CLK,
  input  logic             RN,
  input  logic             EN,
  input  logic [DIV_W-1:0] DIV,
  output logic             Z,
  output logic             TICK,
  output logic             RUN
);

  cd_state_e        state_q, state_nxt;
  logic [DIV_W-1:0] div_q, div_nxt;
  logic             z_nxt, tick_nxt;
  logic             term;
  logic             cnt_clr;

  // Count restarts at every phase end and is held at zero while idle.
  assign cnt_clr = (state_q == CD_IDLE) || term;

  clkdiv_half_cnt #(.DIV_W(DIV_W)) u_half_cnt (
    .clk   (CLK),
    .rst_n (RN),
    .clr   (cnt_clr),
    .limit (div_q),
    .term  (term)
  );

  always_comb begin
    state_nxt = state_q;
    div_nxt   = div_q;
    z_nxt     = Z;
    tick_nxt  = 1'b0;
    case (state_q)
      CD_IDLE: begin
        z_nxt = 1'b0;
        if (EN) begin
          state_nxt = CD_RUN;
          z_nxt     = 1'b1;
          tick_nxt  = 1'b1;
          div_nxt   = DIV;
        end
      end
      CD_RUN: begin
        if (term) begin
          if (Z) begin
            z_nxt = 1'b0;
          end else if (EN) begin
            // Period boundary: the only point where EN and DIV are honoured.
            z_nxt    = 1'b1;
            tick_nxt = 1'b1;
            div_nxt  = DIV;
          end else begin
            state_nxt = CD_IDLE;
            z_nxt     = 1'b0;
          end
        end
      end
      default: begin
        state_nxt = CD_IDLE;
        z_nxt     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state_q <= CD_IDLE;
      div_q   <= '0;
      Z       <= 1'b0;
      TICK    <= 1'b0;
      RUN     <= 1'b0;
    end else begin
      state_q <= state_nxt;
      div_q   <= div_nxt;
      Z       <= z_nxt;
      TICK    <= tick_nxt;
      RUN     <= (state_nxt == CD_RUN);
    end
  end

endmodule
